divider_signed_5_seq: RTL and testbench

Sequential signed divider that inverts the 5x5 signed multiplier: takes a 10-bit signed dividend (product width) and a 5-bit signed divisor and returns a 10-bit signed quotient and 5-bit signed remainder. It uses restoring division on magnitudes, one quotient bit per clock, with a start/busy/done handshake. It sits beside `multiplier_signed_5` in the arithmetic datapath and round-trips its products.

---
 rtl/divider_signed_5_seq.sv | 115 +++++++++++
 tb/tb_divider_signed_5_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/divider_signed_5_seq.sv
// Sequential 10/5 signed divider: restoring division on magnitudes, one quotient
// bit per clock, start/busy/done handshake. Inverts multiplier_signed_5 products.
module divider_signed_5_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] dividend,
  input  logic [4:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [9:0] quotient,
  output logic [4:0] remainder,
  output logic       div_by_zero,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t     state_q;
  logic [9:0] dvd_q;       // dividend magnitude, shifted out MSB first; quotient shifts in
  logic [4:0] dsr_q;
  logic [5:0] rem_q;
  logic [3:0] cnt_q;
  logic       sa_q, sb_q;
  logic       busy_q, done_q, dz_q, ovf_q;
  logic [9:0] quo_q;
  logic [4:0] rmd_q;

  logic [6:0] rem_shift_d;
  logic [6:0] trial_d;
  logic [9:0] quo_d;
  logic [4:0] rmd_d;
  logic       dz_d, ovf_d;
  logic [9:0] dvd_abs_d;
  logic [4:0] dsr_abs_d;

  always_comb begin
    dvd_abs_d   = dividend[9] ? 10'(~dividend + 10'd1) : dividend;
    dsr_abs_d   = divisor[4]  ? 5'(~divisor + 5'd1)    : divisor;
    rem_shift_d = {rem_q, dvd_q[9]};
    trial_d     = rem_shift_d - {2'b00, dsr_q};
    dz_d        = (dsr_q == '0);
    // Only -512 / -1 yields a positive magnitude of 512, which has no 10-bit signed form.
    ovf_d       = !dz_d && !(sa_q ^ sb_q) && (dvd_q == 10'h200);
    quo_d       = (sa_q ^ sb_q) ? 10'(~dvd_q + 10'd1) : dvd_q;
    rmd_d       = sa_q ? 5'(~rem_q[4:0] + 5'd1) : rem_q[4:0];
    if (dz_d) begin
      quo_d = '0;
      rmd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            dvd_q   <= dvd_abs_d;
            dsr_q   <= dsr_abs_d;
            sa_q    <= dividend[9];
            sb_q    <= divisor[4];
            rem_q   <= '0;
            cnt_q   <= 4'd9;
            busy_q  <= 1'b1;
            state_q <= DIV;
          end
        end
        DIV: begin
          if (!trial_d[6]) begin
            rem_q <= trial_d[5:0];
            dvd_q <= {dvd_q[8:0], 1'b1};
          end else begin
            rem_q <= rem_shift_d[5:0];
            dvd_q <= {dvd_q[8:0], 1'b0};
          end
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == '0) state_q <= FIX;
        end
        FIX: begin
          quo_q   <= quo_d;
          rmd_q   <= rmd_d;
          dz_q    <= dz_d;
          ovf_q   <= ovf_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_divider_signed_5_seq.sv
// Directed self-checking bench for divider_signed_5_seq.
module tb_divider_signed_5_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] dividend = '0;
  logic [4:0] divisor = '0;
  logic       busy, done, div_by_zero, overflow;
  logic [9:0] quotient;
  logic [4:0] remainder;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  divider_signed_5_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  // Launch one operation from a negedge; returns at the negedge where done is seen.
  task automatic do_op(input logic [9:0] a, input logic [4:0] b,
                       output int lat, output int busy_cnt);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 30) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0) begin
      fails++;
      $display("FAIL reset_state: got %b, want all zero",
               {busy, done, quotient, remainder, div_by_zero, overflow});
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    do_op(10'd100, 5'd7, lat, bc);
    checks++;
    if (lat !== 11) begin fails++; $display("FAIL basic_latency: got %0d, want 11", lat); end
    checks++;
    if (bc !== 11) begin fails++; $display("FAIL basic_busy_cycles: got %0d, want 11", bc); end
    checks++;
    if (quotient !== 10'd14 || remainder !== 5'd2 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL basic_100_7: got q=%0d r=%0d dz=%b ov=%b, want q=14 r=2 dz=0 ov=0",
               $signed(quotient), $signed(remainder), div_by_zero, overflow);
    end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done: got %b, want 0", busy); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin fails++; $display("FAIL done_one_cycle: got %b, want 0", done); end
    checks++;
    if (quotient !== 10'd14) begin fails++; $display("FAIL result_hold: got %0d, want 14", $signed(quotient)); end
  endtask

  typedef struct {
    logic [9:0] a;
    logic [4:0] b;
    logic [9:0] q;
    logic [4:0] r;
    logic       dz;
    logic       ov;
  } vec_t;

  task automatic test_signs_and_corners();
    vec_t v[7];
    int lat, bc;
    v[0] = '{10'h39C, 5'h07, 10'h3F2, 5'h1E, 1'b0, 1'b0};  // -100 /  7 = -14 r -2
    v[1] = '{10'h064, 5'h19, 10'h3F2, 5'h02, 1'b0, 1'b0};  //  100 / -7 = -14 r  2
    v[2] = '{10'h39C, 5'h19, 10'h00E, 5'h1E, 1'b0, 1'b0};  // -100 / -7 =  14 r -2
    v[3] = '{10'h200, 5'h1F, 10'h200, 5'h00, 1'b0, 1'b1};  // -512 / -1 overflow
    v[4] = '{10'h025, 5'h00, 10'h000, 5'h00, 1'b1, 1'b0};  //   37 /  0
    v[5] = '{10'h200, 5'h01, 10'h200, 5'h00, 1'b0, 1'b0};  // -512 /  1 = -512
    v[6] = '{10'h1FF, 5'h10, 10'h3E1, 5'h0F, 1'b0, 1'b0};  //  511 / -16 = -31 r 15
    foreach (v[i]) begin
      do_op(v[i].a, v[i].b, lat, bc);
      checks++;
      if (lat !== 11 || quotient !== v[i].q || remainder !== v[i].r ||
          div_by_zero !== v[i].dz || overflow !== v[i].ov) begin
        fails++;
        $display("FAIL vector_%0d: got lat=%0d q=%h r=%h dz=%b ov=%b, want lat=11 q=%h r=%h dz=%b ov=%b",
                 i, lat, quotient, remainder, div_by_zero, overflow,
                 v[i].q, v[i].r, v[i].dz, v[i].ov);
      end
    end
  endtask

  task automatic test_round_trip();
    int lat, bc, p;
    for (int a = -16; a <= 15; a++) begin
      for (int b = -16; b <= 15; b++) begin
        if (b != 0) begin
          p = a * b;
          do_op(10'(p), 5'(b), lat, bc);
          checks++;
          if (lat !== 11 || quotient !== 10'(a) || remainder !== 5'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL round_trip %0d/%0d: got lat=%0d q=%0d r=%0d ov=%b, want q=%0d r=0",
                     p, b, lat, $signed(quotient), $signed(remainder), overflow, a);
          end
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    dividend = 10'd100;
    divisor  = 5'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 30) begin
      if (lat == 3 || lat == 7) begin
        dividend = 10'd5;
        divisor  = 5'd1;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++;
    if (lat !== 11 || quotient !== 10'd14 || remainder !== 5'd2) begin
      fails++;
      $display("FAIL start_while_busy: got lat=%0d q=%0d r=%0d, want lat=11 q=14 r=2",
               lat, $signed(quotient), $signed(remainder));
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL no_queued_start: busy=%b, want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    do_op(10'd100, 5'd7, lat, bc);
    do_op(10'd50, 5'd3, lat, bc);
    checks++;
    if (lat !== 11 || bc !== 11 || quotient !== 10'd16 || remainder !== 5'd2) begin
      fails++;
      $display("FAIL back_to_back: got lat=%0d busy=%0d q=%0d r=%0d, want lat=11 busy=11 q=16 r=2",
               lat, bc, $signed(quotient), $signed(remainder));
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, seen;
    dividend = 10'd100;
    divisor  = 5'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0) begin
      fails++;
      $display("FAIL reset_mid_op: got %b, want all zero",
               {busy, done, quotient, remainder, div_by_zero, overflow});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin fails++; $display("FAIL aborted_no_done: got %0d active cycles, want 0", seen); end
    do_op(10'd50, 5'd3, lat, seen);
    checks++;
    if (lat !== 11 || quotient !== 10'd16 || remainder !== 5'd2) begin
      fails++;
      $display("FAIL after_reset_50_3: got lat=%0d q=%0d r=%0d, want lat=11 q=16 r=2",
               lat, $signed(quotient), $signed(remainder));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_signs_and_corners();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_round_trip();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
